// File: rtl/mem_ctrl.sv
// mem_ctrl -- byte-serial memory controller.
//
// Bridges two 32-bit requesters (instruction refill, load/store) onto an
// 8-bit RAM/IO bus. The load/store port wins arbitration. Each access is
// split into little-endian byte transactions at base+k. Read data is
// reassembled into a zero-extended word.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   rdy                   global ready; low freezes the controller
//   if_req/if_addr        instruction word read request (held until if_done)
//   if_flush              drops a pending or in-flight instruction read
//   if_done/if_data       one-cycle completion pulse and assembled word
//   ls_req/ls_we/ls_size  load/store request, direction, size (0=B,1=H,2/3=W)
//   ls_addr/ls_wdata      load/store byte address and store data
//   ls_done/ls_rdata      one-cycle completion pulse and load data
//   busy                  high whenever the controller is not idle
//   mem_din/mem_dout      RAM/IO read byte / write byte
//   mem_a/mem_wr          RAM/IO byte address / write strobe
//
// Bus timing: the RAM returns the byte for the address driven in cycle c
// during cycle c+1. Reads are therefore pipelined one byte deep.

module mem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [DATA_W-1:0] if_data,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_done,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              busy,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    localparam int LANES = DATA_W / 8;
    localparam int IDX_W = $clog2(LANES);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t             state_reg;
    logic [ADDR_W-1:0]  base_reg;
    logic [DATA_W-1:0]  wdata_reg;
    logic [DATA_W-1:0]  buf_reg;
    logic [DATA_W-1:0]  if_data_reg;
    logic [DATA_W-1:0]  ls_rdata_reg;
    logic [CNT_W-1:0]   last_reg;    // index of the final byte (N-1)
    logic [CNT_W-1:0]   cnt_reg;     // read: bytes sampled; write: current byte
    logic               pend_reg;    // read: byte cnt_reg was addressed last cycle
    logic               is_if_reg;
    logic               resume_reg;  // previous cycle had rdy low

    logic [CNT_W-1:0]   ahead;
    logic [CNT_W-1:0]   drive_idx;
    logic [DATA_W-1:0]  buf_next;
    logic [7:0]         wbytes [LANES];

    // Byte lanes: store data slices and read-data merge of the sampled byte.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign wbytes[gi] = wdata_reg[8*gi +: 8];
            assign buf_next[8*gi +: 8] = (cnt_reg == CNT_W'(gi)) ? mem_din
                                                                 : buf_reg[8*gi +: 8];
        end
    endgenerate

    // Next read address index: one ahead of the oldest unsampled byte,
    // clamped at the last byte so nothing past base+N-1 is ever addressed.
    // In the first cycle after a stall the oldest unsampled byte is
    // addressed again, since its earlier response was not captured.
    assign ahead = cnt_reg + CNT_W'(pend_reg);

    always_comb begin
        drive_idx = '0;
        if (state_reg == READ) begin
            if (rdy && resume_reg)
                drive_idx = cnt_reg;
            else if (ahead > last_reg)
                drive_idx = last_reg;
            else
                drive_idx = ahead;
        end else if (state_reg == WRITE) begin
            drive_idx = cnt_reg;
        end
    end

    assign mem_a    = (state_reg == READ || state_reg == WRITE)
                      ? base_reg + ADDR_W'(drive_idx) : '0;
    assign mem_dout = (state_reg == WRITE) ? wbytes[cnt_reg[IDX_W-1:0]] : 8'h00;
    assign mem_wr   = (state_reg == WRITE) && rdy;
    assign busy     = (state_reg != IDLE);
    assign if_done  = (state_reg == DONE) && is_if_reg && rdy && !if_flush;
    assign ls_done  = (state_reg == DONE) && !is_if_reg && rdy;
    assign if_data  = if_data_reg;
    assign ls_rdata = ls_rdata_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            base_reg     <= '0;
            wdata_reg    <= '0;
            buf_reg      <= '0;
            if_data_reg  <= '0;
            ls_rdata_reg <= '0;
            last_reg     <= '0;
            cnt_reg      <= '0;
            pend_reg     <= 1'b0;
            is_if_reg    <= 1'b0;
            resume_reg   <= 1'b0;
        end else begin
            resume_reg <= !rdy;
            if (rdy) begin
                case (state_reg)
                    IDLE: begin
                        cnt_reg  <= '0;
                        pend_reg <= 1'b0;
                        buf_reg  <= '0;
                        if (ls_req) begin
                            base_reg  <= ls_addr;
                            wdata_reg <= ls_wdata;
                            is_if_reg <= 1'b0;
                            case (ls_size)
                                2'd0:    last_reg <= CNT_W'(0);
                                2'd1:    last_reg <= CNT_W'(1);
                                default: last_reg <= CNT_W'(LANES - 1);
                            endcase
                            state_reg <= ls_we ? WRITE : READ;
                        end else if (if_req && !if_flush) begin
                            base_reg  <= if_addr;
                            is_if_reg <= 1'b1;
                            last_reg  <= CNT_W'(LANES - 1);
                            state_reg <= READ;
                        end
                    end
                    READ: begin
                        if (is_if_reg && if_flush) begin
                            state_reg <= IDLE;
                            pend_reg  <= 1'b0;
                        end else if (resume_reg) begin
                            // Re-addressing the oldest byte; nothing valid to sample.
                            pend_reg <= 1'b1;
                        end else begin
                            if (pend_reg) begin
                                buf_reg <= buf_next;
                                cnt_reg <= cnt_reg + 1'b1;
                                if (cnt_reg == last_reg) begin
                                    state_reg <= DONE;
                                    if (is_if_reg)
                                        if_data_reg <= buf_next;
                                    else
                                        ls_rdata_reg <= buf_next;
                                end
                            end
                            pend_reg <= (ahead <= last_reg);
                        end
                    end
                    WRITE: begin
                        // A stalled byte was not strobed, so it simply repeats here.
                        if (cnt_reg == last_reg)
                            state_reg <= DONE;
                        else
                            cnt_reg <= cnt_reg + 1'b1;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl with a one-cycle-latency byte RAM model.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_flush = 1'b0;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [1:0]  ls_size = '0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        busy;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int if_cnt = 0;
    int ls_cnt = 0;
    int wr_cnt = 0;
    int w0;
    bit loaded = 1'b0;

    logic [7:0] ram [logic [31:0]];

    mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_done(ls_done), .ls_rdata(ls_rdata), .busy(busy),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    // Synchronous byte RAM: address in cycle c, data visible in cycle c+1.
    always @(posedge clk) begin
        if (rst && !loaded) begin
            ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05;
            ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
            ram[32'h2000] = 8'hAA; ram[32'h2001] = 8'hBB;
            ram[32'h2002] = 8'hCC; ram[32'h2003] = 8'hDD;
            ram[32'h3000] = 8'h11; ram[32'h3001] = 8'h22;
            ram[32'h3002] = 8'h33; ram[32'h3003] = 8'h44;
            ram[32'h0102] = 8'h77;
            loaded = 1'b1;
        end
        mem_din <= rd(mem_a);
        if (mem_wr) begin
            ram[mem_a] = mem_dout;
            wr_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs for cycle c are driven between begin_cycle and end_cycle.
    task automatic begin_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic end_cycle();
        #1;
        if (if_done) if_cnt++;
        if (ls_done) ls_cnt++;
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            begin_cycle();
            end_cycle();
        end
    endtask

    task automatic start_txn();
        begin_cycle();
        cyc = 0;
        if_cnt = 0;
        ls_cnt = 0;
        w0 = wr_cnt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        // Reset state
        adv(3);
        chk("rst_busy", busy, 0);
        chk("rst_if_done", if_done, 0);
        chk("rst_ls_done", ls_done, 0);
        chk("rst_if_data", if_data, 0);
        chk("rst_ls_rdata", ls_rdata, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_dout", mem_dout, 0);
        chk("rst_mem_wr", mem_wr, 0);
        begin_cycle(); rst = 1'b0; end_cycle();
        adv(1);

        // 1: instruction word read at 0x1000
        start_txn(); if_req = 1'b1; if_addr = 32'h1000; end_cycle();
        chk("t1_c0_busy", busy, 0);
        for (int c = 1; c <= 4; c++) begin
            adv(1);
            chk("t1_mem_a", mem_a, 32'h1000 + 32'(c - 1));
            chk("t1_mem_wr", mem_wr, 0);
        end
        adv(1); chk("t1_c5_no_done", if_cnt, 0);
        adv(1);
        chk("t1_if_done", if_done, 1);
        chk("t1_if_data", if_data, 32'h0000_0513);
        chk("t1_if_cnt", if_cnt, 1);
        if_req = 1'b0;
        $display("[%0t] IF read 0x1000 -> %h at cycle %0d", $time, if_data, cyc);

        // 2: simultaneous IF and load word, load wins
        start_txn();
        if_req = 1'b1; if_addr = 32'h2000;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = 32'h3000;
        end_cycle();
        adv(5); chk("t2_c5_no_ls_done", ls_cnt, 0);
        adv(1);
        chk("t2_ls_done", ls_done, 1);
        chk("t2_ls_rdata", ls_rdata, 32'h4433_2211);
        chk("t2_if_not_done", if_done, 0);
        ls_req = 1'b0;
        adv(1); chk("t2_c7_idle", busy, 0);
        adv(5); chk("t2_c12_no_if_done", if_cnt, 0);
        adv(1);
        chk("t2_if_done", if_done, 1);
        chk("t2_if_data", if_data, 32'hDDCC_BBAA);
        if_req = 1'b0;
        $display("[%0t] LW 0x3000 -> %h then IF 0x2000 -> %h at cycle %0d", $time, ls_rdata, if_data, cyc);

        // 3: store byte 0x41 to 0x30000
        start_txn();
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h3_0000; ls_wdata = 32'hDEAD_BE41;
        end_cycle();
        adv(1);
        chk("t3_mem_wr", mem_wr, 1);
        chk("t3_mem_a", mem_a, 32'h3_0000);
        chk("t3_mem_dout", mem_dout, 32'h41);
        adv(1);
        chk("t3_ls_done", ls_done, 1);
        chk("t3_c2_mem_wr", mem_wr, 0);
        ls_req = 1'b0;
        adv(2);
        chk("t3_write_count", wr_cnt - w0, 1);
        chk("t3_ram", rd(32'h3_0000), 32'h41);
        $display("[%0t] SB 0x41 -> 0x30000", $time);

        // 4: store half then load half at 0x100
        start_txn();
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd1; ls_addr = 32'h100; ls_wdata = 32'h1234_BEEF;
        end_cycle();
        adv(1);
        chk("t4_c1_a", mem_a, 32'h100); chk("t4_c1_d", mem_dout, 32'hEF); chk("t4_c1_wr", mem_wr, 1);
        adv(1);
        chk("t4_c2_a", mem_a, 32'h101); chk("t4_c2_d", mem_dout, 32'hBE); chk("t4_c2_wr", mem_wr, 1);
        adv(1);
        chk("t4_sh_done", ls_done, 1);
        ls_req = 1'b0;
        start_txn();
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd1; ls_addr = 32'h100;
        end_cycle();
        adv(3); chk("t4_no_addr_102", mem_a == 32'h102, 0);
        adv(1);
        chk("t4_lh_done", ls_done, 1);
        chk("t4_lh_rdata", ls_rdata, 32'h0000_BEEF);
        ls_req = 1'b0;
        $display("[%0t] SH 0xBEEF -> 0x100, LH 0x100 -> %h", $time, ls_rdata);

        // 5: IF read flushed in cycle 3, pending byte load then served
        start_txn(); if_req = 1'b1; if_addr = 32'h1000; end_cycle();
        adv(2);
        begin_cycle();
        if_flush = 1'b1;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h3001;
        end_cycle();
        adv(1);
        chk("t5_c4_idle", busy, 0);
        chk("t5_c4_mem_a", mem_a, 0);
        if_req = 1'b0; if_flush = 1'b0;
        adv(1); chk("t5_c5_mem_a", mem_a, 32'h3001);
        adv(2);
        chk("t5_ls_done", ls_done, 1);
        chk("t5_ls_rdata", ls_rdata, 32'h0000_0022);
        chk("t5_no_if_done", if_cnt, 0);
        ls_req = 1'b0;
        $display("[%0t] IF 0x1000 flushed, LBU 0x3001 -> %h", $time, ls_rdata);

        // 6: rdy low in cycles 3-4 of an IF word read
        start_txn(); if_req = 1'b1; if_addr = 32'h2000; end_cycle();
        adv(2);
        begin_cycle(); rdy = 1'b0; end_cycle(); chk("t6_c3_wr", mem_wr, 0);
        adv(1); chk("t6_c4_wr", mem_wr, 0);
        begin_cycle(); rdy = 1'b1; end_cycle(); chk("t6_c5_redrive", mem_a, 32'h2001);
        adv(1); chk("t6_c6_a", mem_a, 32'h2002);
        adv(1); chk("t6_c7_a", mem_a, 32'h2003);
        adv(1); chk("t6_c8_no_done", if_cnt, 0);
        adv(1);
        chk("t6_if_done", if_done, 1);
        chk("t6_if_data", if_data, 32'hDDCC_BBAA);
        if_req = 1'b0;
        $display("[%0t] IF 0x2000 with stall -> %h at cycle %0d", $time, if_data, cyc);

        // 6b: rdy low during a word store re-issues the current byte
        start_txn();
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h400; ls_wdata = 32'hCAFE_F00D;
        end_cycle();
        adv(1); chk("t6b_c1_d", mem_dout, 32'h0D); chk("t6b_c1_wr", mem_wr, 1);
        begin_cycle(); rdy = 1'b0; end_cycle(); chk("t6b_c2_wr", mem_wr, 0);
        begin_cycle(); rdy = 1'b1; end_cycle();
        chk("t6b_c3_a", mem_a, 32'h401); chk("t6b_c3_d", mem_dout, 32'hF0); chk("t6b_c3_wr", mem_wr, 1);
        adv(2); chk("t6b_c5_a", mem_a, 32'h403); chk("t6b_c5_d", mem_dout, 32'hCA);
        adv(1); chk("t6b_ls_done", ls_done, 1);
        ls_req = 1'b0;
        adv(1);
        chk("t6b_write_count", wr_cnt - w0, 4);
        chk("t6b_ram", {rd(32'h403), rd(32'h402), rd(32'h401), rd(32'h400)}, 32'hCAFE_F00D);
        $display("[%0t] SW 0xCAFEF00D -> 0x400 with stall", $time);

        // 7: reset in cycle 2 of a word store
        start_txn();
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h500; ls_wdata = 32'h1122_3344;
        end_cycle();
        adv(1);
        begin_cycle(); rst = 1'b1; ls_req = 1'b0; end_cycle();
        begin_cycle(); rst = 1'b0; end_cycle();
        chk("t7_busy", busy, 0);
        chk("t7_mem_wr", mem_wr, 0);
        chk("t7_mem_a", mem_a, 0);
        chk("t7_mem_dout", mem_dout, 0);
        chk("t7_ls_rdata", ls_rdata, 0);
        chk("t7_if_data", if_data, 0);
        adv(4);
        chk("t7_no_ls_done", ls_cnt, 0);
        chk("t7_byte0_kept", rd(32'h500), 32'h44);
        $display("[%0t] SW 0x500 aborted by reset", $time);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
